router_stat_readout_ctrl: RTL and testbench

Synthesizable per-router, per-port traffic counter bank with a readout sequencer. It counts flit and packet events at every router port and, on request, streams all counters out one word at a time over a valid/ready interface. An optional clear-on-read mode is latched per dump. It sits beside the NoC as the hardware counterpart of the simulation-only statistics collector, so router statistics can be read on FPGA.

---
 rtl/router_stat_readout_ctrl.sv | 146 ++++++++++++++
 tb/tb_router_stat_readout_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/router_stat_readout_ctrl.sv
// Per-router, per-port flit/packet event counters with a valid/ready readout sequencer.
// A dump streams every counter once, field fastest, then port, then router.
module router_stat_readout_ctrl #(
  parameter int NR    = 4,
  parameter int MAX_P = 5,
  parameter int CNT_W = 32,
  localparam int NP    = NR * MAX_P,
  localparam int NW    = NP * 4,
  localparam int RID_W = (NR > 1) ? $clog2(NR) : 1,
  localparam int PID_W = (MAX_P > 1) ? $clog2(MAX_P) : 1,
  localparam int IDX_W = $clog2(NW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NP-1:0]    flit_wr_i,
  input  logic [NP-1:0]    pck_wr_i,
  input  logic [NP-1:0]    flit_wr_o,
  input  logic [NP-1:0]    pck_wr_o,
  input  logic             start,
  input  logic             clear_on_read,
  output logic             busy,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] dout_data,
  output logic [RID_W-1:0] dout_rid,
  output logic [PID_W-1:0] dout_pid,
  output logic [1:0]       dout_field,
  output logic             dout_last
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic             cor_q;
  logic [CNT_W-1:0] cnt [NW];
  logic [NW-1:0]    ev;

  logic             load_en;
  logic             cor_eff;
  logic [RID_W-1:0] nxt_rid;
  logic [PID_W-1:0] nxt_pid;
  logic [1:0]       nxt_field;
  logic             nxt_last;
  logic [IDX_W-1:0] load_idx;

  // Flatten the four event vectors into word order so counter w matches word w.
  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_ev
      assign ev[gi*4+0] = flit_wr_i[gi];
      assign ev[gi*4+1] = pck_wr_i[gi];
      assign ev[gi*4+2] = flit_wr_o[gi];
      assign ev[gi*4+3] = pck_wr_o[gi];
    end
  endgenerate

  always_comb begin
    load_en   = 1'b0;
    cor_eff   = cor_q;
    nxt_rid   = dout_rid;
    nxt_pid   = dout_pid;
    nxt_field = dout_field;
    if (state == IDLE) begin
      // The first word must already honour the mode requested with start.
      if (start) begin
        load_en   = 1'b1;
        cor_eff   = clear_on_read;
        nxt_rid   = '0;
        nxt_pid   = '0;
        nxt_field = '0;
      end
    end else if (dout_ready && !dout_last) begin
      load_en = 1'b1;
      if (dout_field == 2'd3) begin
        nxt_field = '0;
        if (dout_pid == PID_W'(MAX_P - 1)) begin
          nxt_pid = '0;
          nxt_rid = dout_rid + RID_W'(1);
        end else begin
          nxt_pid = dout_pid + PID_W'(1);
        end
      end else begin
        nxt_field = dout_field + 2'd1;
      end
    end
  end

  assign nxt_last = (nxt_rid == RID_W'(NR - 1)) && (nxt_pid == PID_W'(MAX_P - 1)) &&
                    (nxt_field == 2'd3);
  assign load_idx = IDX_W'((int'(nxt_rid) * MAX_P + int'(nxt_pid)) * 4 + int'(nxt_field));

  // Clear-on-read restarts at 1 when the word's own event coincides with its load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (load_en && cor_eff && load_idx == IDX_W'(i))
          cnt[i] <= ev[i] ? CNT_W'(1) : '0;
        else if (ev[i] && cnt[i] != '1)
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cor_q      <= 1'b0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_rid   <= '0;
      dout_pid   <= '0;
      dout_field <= '0;
      dout_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SEND;
            cor_q      <= clear_on_read;
            busy       <= 1'b1;
            dout_valid <= 1'b1;
          end
        end
        SEND: begin
          if (dout_ready && dout_last) begin
            state      <= IDLE;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (load_en) begin
        dout_data  <= cnt[load_idx];
        dout_rid   <= nxt_rid;
        dout_pid   <= nxt_pid;
        dout_field <= nxt_field;
        dout_last  <= nxt_last;
      end
    end
  end

endmodule

// File: tb/tb_router_stat_readout_ctrl.sv
// Directed bench for router_stat_readout_ctrl on a 2x2 router array with 4-bit counters.
module tb_router_stat_readout_ctrl;

  localparam int NR = 2, MAX_P = 2, CNT_W = 4, NP = 4, NW = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NP-1:0]    flit_wr_i = '0, pck_wr_i = '0, flit_wr_o = '0, pck_wr_o = '0;
  logic             start = 1'b0, clear_on_read = 1'b0;
  logic             busy, dout_valid;
  logic             dout_ready = 1'b1;
  logic [CNT_W-1:0] dout_data;
  logic             dout_rid, dout_pid;
  logic [1:0]       dout_field;
  logic             dout_last;

  int total = 0;
  int bad   = 0;
  int exp_data [NW];

  router_stat_readout_ctrl #(.NR(NR), .MAX_P(MAX_P), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .flit_wr_i(flit_wr_i), .pck_wr_i(pck_wr_i), .flit_wr_o(flit_wr_o), .pck_wr_o(pck_wr_o),
    .start(start), .clear_on_read(clear_on_read), .busy(busy),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_rid(dout_rid), .dout_pid(dout_pid), .dout_field(dout_field), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NW; i++) exp_data[i] = 0;
  endtask

  // which: 0 flit_wr_i, 1 pck_wr_i, 2 flit_wr_o, 3 pck_wr_o
  task automatic pulse(input int which, input int b, input int n);
    case (which)
      0: flit_wr_i[b] = 1'b1;
      1: pck_wr_i[b]  = 1'b1;
      2: flit_wr_o[b] = 1'b1;
      default: pck_wr_o[b] = 1'b1;
    endcase
    repeat (n) tick();
    flit_wr_i = '0; pck_wr_i = '0; flit_wr_o = '0; pck_wr_o = '0;
  endtask

  // One full dump; optional stall (with pck_wr_i[1] events) and a start pulse while busy.
  task automatic run_dump(input string name, input logic cor, input logic ev0,
                          input int stall_w, input int stall_n, input int bstart_w);
    int busy_n = 0;
    start = 1'b1; clear_on_read = cor;
    if (ev0) flit_wr_i[0] = 1'b1;
    tick();
    start = 1'b0; clear_on_read = 1'b0; flit_wr_i[0] = 1'b0;
    for (int w = 0; w < NW; w++) begin
      if (busy) busy_n++;
      chk($sformatf("%s w%0d valid", name, w), 32'(dout_valid), 1);
      chk($sformatf("%s w%0d data", name, w), 32'(dout_data), exp_data[w]);
      chk($sformatf("%s w%0d rid", name, w), 32'(dout_rid), w / 8);
      chk($sformatf("%s w%0d pid", name, w), 32'(dout_pid), (w / 4) % 2);
      chk($sformatf("%s w%0d field", name, w), 32'(dout_field), w % 4);
      chk($sformatf("%s w%0d last", name, w), 32'(dout_last), (w == NW - 1) ? 1 : 0);
      $display("%s word %0d r=%0d p=%0d f=%0d data=%0d last=%0d",
               name, w, dout_rid, dout_pid, dout_field, dout_data, dout_last);
      if (w == bstart_w) start = 1'b1;
      if (w == stall_w) begin
        dout_ready = 1'b0;
        pck_wr_i[1] = 1'b1;
        repeat (stall_n) begin
          tick();
          start = 1'b0;
          if (busy) busy_n++;
          chk($sformatf("%s stall data", name), 32'(dout_data), exp_data[w]);
          chk($sformatf("%s stall field", name), 32'(dout_field), w % 4);
          chk($sformatf("%s stall valid", name), 32'(dout_valid), 1);
        end
        dout_ready = 1'b1;
        pck_wr_i[1] = 1'b0;
      end
      tick();
      start = 1'b0;
    end
    chk($sformatf("%s end busy", name), 32'(busy), 0);
    chk($sformatf("%s end valid", name), 32'(dout_valid), 0);
    chk($sformatf("%s busy cycles", name), busy_n, NW + ((stall_w >= 0) ? stall_n : 0));
    tick();
    chk($sformatf("%s idle valid", name), 32'(dout_valid), 0);
  endtask

  initial begin
    repeat (2) tick();
    chk("reset busy", 32'(busy), 0);
    chk("reset valid", 32'(dout_valid), 0);
    chk("reset data", 32'(dout_data), 0);
    chk("reset last", 32'(dout_last), 0);
    chk("reset field", 32'(dout_field), 0);
    reset = 1'b0;
    tick();

    // Count and dump
    pulse(0, 3, 5);
    pulse(3, 0, 2);
    clear_exp();
    exp_data[12] = 5; exp_data[3] = 2;
    run_dump("count", 1'b0, 1'b0, -1, 0, -1);

    // Backpressure on word 2; word 5 collects the stall-time events
    exp_data[5] = 4;
    run_dump("bp", 1'b0, 1'b0, 2, 4, -1);

    // Clear-on-read with an event on word 0 exactly at its load edge
    exp_data[5] = 0;
    exp_data[5] = 4;
    run_dump("cor1", 1'b1, 1'b1, -1, 0, -1);
    clear_exp();
    exp_data[0] = 1;
    run_dump("cor2", 1'b1, 1'b0, -1, 0, -1);

    // Saturation at 15
    pulse(2, 2, 20);
    clear_exp();
    exp_data[10] = 15;
    run_dump("sat", 1'b1, 1'b0, -1, 0, -1);

    // Start while busy is ignored
    clear_exp();
    run_dump("bstart", 1'b0, 1'b0, -1, 0, 4);

    // Reset mid-dump at word 7
    pulse(0, 3, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("mid w7 field", 32'(dout_field), 3);
    chk("mid w7 pid", 32'(dout_pid), 1);
    reset = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst valid", 32'(dout_valid), 0);
    chk("rst data", 32'(dout_data), 0);
    chk("rst pid", 32'(dout_pid), 0);
    chk("rst field", 32'(dout_field), 0);
    chk("rst last", 32'(dout_last), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    pulse(1, 2, 3);
    clear_exp();
    exp_data[9] = 3;
    run_dump("post", 1'b0, 1'b0, -1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
